// File: rtl/vec_lane_streamer_if.sv
// vec_lane_streamer_if: stream request, data-memory read port and lane output bundle.
// out_parity is present only when VSTREAM_PARITY_EN is defined.
interface vec_lane_streamer_if #(
  parameter int N     = 16,
  parameter int LANES = 16
);
  logic                 start;
  logic [31:0]          base_addr;
  logic [7:0]           count;
  logic [LANES*N-1:0]   mem_rdata;
  logic                 out_ready;
  logic [31:0]          mem_addr;
  logic                 mem_rd_en;
  logic [N-1:0]         out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 busy;
  logic                 done;
`ifdef VSTREAM_PARITY_EN
  logic                 out_parity;
  modport slave (
    input  start, base_addr, count, mem_rdata, out_ready,
    output mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done, out_parity
  );
  modport master (
    output start, base_addr, count, mem_rdata, out_ready,
    input  mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done, out_parity
  );
`else
  modport slave (
    input  start, base_addr, count, mem_rdata, out_ready,
    output mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done
  );
  modport master (
    output start, base_addr, count, mem_rdata, out_ready,
    input  mem_addr, mem_rd_en, out_data, out_valid, out_last, busy, done
  );
`endif
endinterface

// File: rtl/vec_lane_streamer.sv
// vec_lane_streamer: reads vector words from data memory and streams their lanes one beat at a time.
// Optional out_parity output enabled by defining VSTREAM_PARITY_EN.
module vec_lane_streamer #(
  parameter int N     = 16,
  parameter int LANES = 16
) (
  input  logic             CLK,
  input  logic             reset,
  vec_lane_streamer_if.slave bus
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  logic [2:0]              r_state;
  logic [31:0]             r_base;
  logic [31:0]             r_addr;
  logic [7:0]              r_cnt;
  logic [7:0]              r_vec;
  logic [LW-1:0]           r_lane;
  logic [LANES-1:0][N-1:0] r_buf;
  logic                    w_stream;
  logic                    w_lane_end;
  logic                    w_vec_last;
  assign w_stream   = r_state == S_STREAM;
  assign w_lane_end = r_lane == LW'(LANES - 1);
  assign w_vec_last = r_vec == r_cnt - 8'd1;
  // r_addr is loaded only when entering READ, so it holds between reads
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_lane  <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= bus.count != 8'd0 ? S_READ : S_DONE;
          if (bus.count != 8'd0) begin
            r_base <= bus.base_addr;
            r_addr <= bus.base_addr;
            r_cnt  <= bus.count;
            r_vec  <= '0;
            r_lane <= '0;
          end
        end
        S_READ: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_buf   <= bus.mem_rdata;
          r_state <= S_STREAM;
        end
        S_STREAM: if (bus.out_ready) begin
          if (!w_lane_end) r_lane <= r_lane + LW'(1);
          else if (w_vec_last) r_state <= S_DONE;
          else begin
            r_vec   <= r_vec + 8'd1;
            r_lane  <= '0;
            r_addr  <= r_base + 32'(r_vec) + 32'd1;
            r_state <= S_READ;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.mem_rd_en = r_state == S_READ;
  assign bus.mem_addr  = r_addr;
  assign bus.out_valid = w_stream;
  assign bus.out_data  = w_stream ? r_buf[r_lane] : '0;
  assign bus.out_last  = w_stream && w_lane_end && w_vec_last;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.done      = r_state == S_DONE;
`ifdef VSTREAM_PARITY_EN
  assign bus.out_parity = w_stream && (^r_buf[r_lane]);
`endif
endmodule

// File: tb/tb_vec_lane_streamer.sv
// tb_vec_lane_streamer: directed checks of vec_lane_streamer against a bench-side memory pattern.
// Checks out_parity as well when VSTREAM_PARITY_EN is defined.
module tb_vec_lane_streamer;
  localparam int N     = 16;
  localparam int LANES = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_lane_streamer_if #(.N(N), .LANES(LANES)) vif ();
  vec_lane_streamer #(.N(N), .LANES(LANES)) dut (.CLK(clk), .reset(rst), .bus(vif));
  always #5 clk = ~clk;
  function automatic logic [15:0] lane_val(input logic [31:0] a, input int l);
    return 16'(((a - 32'h10) << 8) | 32'(l));
  endfunction
  always @(posedge clk)
    if (vif.mem_rd_en)
      for (int l = 0; l < LANES; l++) vif.mem_rdata[l*N +: N] <= lane_val(vif.mem_addr, l);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_en"}, 32'(vif.mem_rd_en), 0);
    chk({tag, "_valid"}, 32'(vif.out_valid), 0);
    chk({tag, "_data"}, 32'(vif.out_data), 0);
    chk({tag, "_last"}, 32'(vif.out_last), 0);
`ifdef VSTREAM_PARITY_EN
    chk({tag, "_parity"}, 32'(vif.out_parity), 0);
`endif
  endtask
  task automatic run_stream(input logic [31:0] base, input logic [7:0] cnt, input bit toggle, input bit inj);
    int cyc   = 0;
    int beats = 0;
    int lasts = 0;
    bit rdy;
    vif.start = 1'b1;
    vif.base_addr = base;
    vif.count = cnt;
    @(negedge clk);
    vif.start = 1'b0;
    vif.base_addr = 32'h0000_0BAD;
    for (int v = 0; v < int'(cnt); v++) begin
      chk("read_en", 32'(vif.mem_rd_en), 1);
      chk("read_addr", vif.mem_addr, base + 32'(v));
      chk("read_valid", 32'(vif.out_valid), 0);
      @(negedge clk);
      chk("cap_en", 32'(vif.mem_rd_en), 0);
      chk("cap_addr", vif.mem_addr, base + 32'(v));
      chk("cap_valid", 32'(vif.out_valid), 0);
      chk("cap_busy", 32'(vif.busy), 1);
      @(negedge clk);
      for (int l = 0, g = 0; l < LANES && g < 200; g++) begin
        chk("valid", 32'(vif.out_valid), 1);
        chk("data", 32'(vif.out_data), 32'(lane_val(base + 32'(v), l)));
        chk("last", 32'(vif.out_last), 32'(v == int'(cnt) - 1 && l == LANES - 1));
        chk("strm_rd_en", 32'(vif.mem_rd_en), 0);
        chk("strm_done", 32'(vif.done), 0);
`ifdef VSTREAM_PARITY_EN
        chk("parity", 32'(vif.out_parity), 32'(^lane_val(base + 32'(v), l)));
`endif
        rdy = toggle ? (cyc % 2 == 1) : 1'b1;
        if (rdy && vif.out_last) lasts++;
        vif.out_ready = rdy;
        vif.start = inj && v == 0 && cyc == 3;
        if (vif.start) vif.base_addr = 32'h0000_0500;
        @(negedge clk);
        cyc++;
        vif.start = 1'b0;
        if (rdy) begin
          l++;
          beats++;
        end
      end
    end
    vif.out_ready = 1'b1;
    chk("beats", 32'(beats), 32'(int'(cnt) * LANES));
    chk("last_count", 32'(lasts), 1);
    chk("done", 32'(vif.done), 1);
    chk("done_busy", 32'(vif.busy), 1);
    chk_quiet("done");
    @(negedge clk);
    chk("idle_busy", 32'(vif.busy), 0);
    chk("idle_done", 32'(vif.done), 0);
  endtask
  initial begin
    vif.start = 1'b0;
    vif.base_addr = '0;
    vif.count = '0;
    vif.out_ready = 1'b1;
    vif.mem_rdata = '0;
    @(negedge clk);
    chk("rst_addr", vif.mem_addr, 0);
    chk("rst_busy", 32'(vif.busy), 0);
    chk("rst_done", 32'(vif.done), 0);
    chk_quiet("rst");
    rst = 1'b0;
    run_stream(32'h10, 8'd1, 1'b0, 1'b0);
    run_stream(32'h20, 8'd2, 1'b1, 1'b0);
    vif.start = 1'b1;
    vif.count = 8'd0;
    vif.base_addr = 32'h40;
    @(negedge clk);
    vif.start = 1'b0;
    chk("zero_busy", 32'(vif.busy), 1);
    chk("zero_done", 32'(vif.done), 1);
    chk_quiet("zero");
    @(negedge clk);
    chk("zero_idle_busy", 32'(vif.busy), 0);
    chk("zero_idle_done", 32'(vif.done), 0);
    chk_quiet("zero_idle");
    vif.start = 1'b1;
    vif.count = 8'd1;
    vif.base_addr = 32'h10;
    @(negedge clk);
    vif.start = 1'b0;
    repeat (2) @(negedge clk);
    repeat (7) @(negedge clk);
    chk("pre_rst_data", 32'(vif.out_data), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", vif.mem_addr, 0);
    chk("arst_busy", 32'(vif.busy), 0);
    chk("arst_done", 32'(vif.done), 0);
    chk_quiet("arst");
    @(negedge clk);
    chk("arst_hold_done", 32'(vif.done), 0);
    chk("arst_hold_busy", 32'(vif.busy), 0);
    rst = 1'b0;
    run_stream(32'h10, 8'd1, 1'b0, 1'b0);
    run_stream(32'h30, 8'd2, 1'b0, 1'b1);
    run_stream(32'hFFFF_FFFF, 8'd2, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
